// File: rtl/sword_hitbox.sv
// sword_hitbox: melee swing FSM paced by the slow game tick.
// SwordBox is a pixel-aligned hitbox test, live only while ACTIVE.
module sword_hitbox #(
    parameter int unsigned WINDUP_TICKS   = 4,
    parameter int unsigned ACTIVE_TICKS   = 12,
    parameter int unsigned COOLDOWN_TICKS = 20,
    parameter int unsigned SWORD_W        = 24,
    parameter int unsigned SWORD_H        = 8,
    parameter int unsigned SWORD_YOFF     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        attack_btn,
    input  logic [31:0] player_posX,
    input  logic [31:0] player_posY,
    input  logic        facing_left,
    input  logic [31:0] CounterX,
    input  logic [31:0] CounterY,
    output logic        SwordBox,
    output logic        sword_active,
    output logic [1:0]  sword_state,
    output logic [7:0]  swing_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WINDUP   = 2'd1,
        ACTIVE   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    // A zero-length phase still lasts one tick.
    localparam logic [31:0] WINDUP_LAST =
        (WINDUP_TICKS == 0) ? 32'd0 : 32'(WINDUP_TICKS - 1);
    localparam logic [31:0] ACTIVE_LAST =
        (ACTIVE_TICKS == 0) ? 32'd0 : 32'(ACTIVE_TICKS - 1);
    localparam logic [31:0] COOLDOWN_LAST =
        (COOLDOWN_TICKS == 0) ? 32'd0 : 32'(COOLDOWN_TICKS - 1);

    localparam logic [31:0] SW_W  = 32'(SWORD_W);
    localparam logic [31:0] SW_YO = 32'(SWORD_YOFF);
    localparam logic [31:0] SW_YT = 32'(SWORD_YOFF + SWORD_H);

    state_t      state;
    logic [31:0] tickCnt;
    logic        btn_q;
    logic        btnArmed;
    logic        dir_l;
    logic        press;
    logic [31:0] boxL;
    logic [31:0] boxR;
    logic [31:0] boxT;
    logic [31:0] boxB;

    // btnArmed blocks a button held across reset from firing.
    assign press       = attack_btn & ~btn_q & btnArmed;
    assign sword_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tickCnt      <= '0;
            btn_q        <= 1'b0;
            btnArmed     <= 1'b0;
            dir_l        <= 1'b0;
            swing_count  <= '0;
            sword_active <= 1'b0;
        end else begin
            btn_q <= attack_btn;
            if (!attack_btn)
                btnArmed <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (press) begin
                        state   <= WINDUP;
                        tickCnt <= '0;
                        dir_l   <= facing_left;
                        if (swing_count != 8'hFF)
                            swing_count <= swing_count + 8'd1;
                    end
                end
                WINDUP: begin
                    if (tick) begin
                        if (tickCnt == WINDUP_LAST) begin
                            state        <= ACTIVE;
                            sword_active <= 1'b1;
                            tickCnt      <= '0;
                        end else begin
                            tickCnt <= tickCnt + 32'd1;
                        end
                    end
                end
                ACTIVE: begin
                    if (tick) begin
                        if (tickCnt == ACTIVE_LAST) begin
                            state        <= COOLDOWN;
                            sword_active <= 1'b0;
                            tickCnt      <= '0;
                        end else begin
                            tickCnt <= tickCnt + 32'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (tick) begin
                        if (tickCnt == COOLDOWN_LAST) begin
                            state   <= IDLE;
                            tickCnt <= '0;
                        end else begin
                            tickCnt <= tickCnt + 32'd1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    sword_active <= 1'b0;
                    tickCnt      <= '0;
                end
            endcase
        end
    end

    // Edges clamp at 0; a clamped bottom/right edge of 0 yields an empty box.
    always_comb begin
        boxL = '0;
        boxR = '0;
        if (dir_l) begin
            boxL = (player_posX >= SW_W) ? player_posX - SW_W : '0;
            boxR = player_posX;
        end else begin
            boxL = player_posX + 32'd32;
            boxR = player_posX + 32'd32 + SW_W;
        end
        boxT = (player_posY >= SW_YT) ? player_posY - SW_YT : '0;
        boxB = (player_posY >= SW_YO) ? player_posY - SW_YO : '0;
    end

    assign SwordBox = (state == ACTIVE)
                    && (CounterX >= boxL) && (CounterX < boxR)
                    && (CounterY >= boxT) && (CounterY < boxB);

endmodule

// File: tb/tb_sword_hitbox.sv
// Bench for sword_hitbox: table-driven hitbox vectors, directed swing
// sequences and randomized traffic against a swing-timeline model.
module tb_sword_hitbox;

    localparam int W   = 4;
    localparam int A   = 12;
    localparam int C   = 20;
    localparam int SW  = 24;
    localparam int SH  = 8;
    localparam int SYO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        attack_btn;
    logic [31:0] player_posX;
    logic [31:0] player_posY;
    logic        facing_left;
    logic [31:0] CounterX;
    logic [31:0] CounterY;
    logic        SwordBox;
    logic        sword_active;
    logic [1:0]  sword_state;
    logic [7:0]  swing_count;

    logic        zBox;
    logic        zActive;
    logic [1:0]  zState;
    logic [7:0]  zCount;

    always #5 clk = ~clk;

    sword_hitbox dut (
        .clk(clk), .rst(rst), .tick(tick), .attack_btn(attack_btn),
        .player_posX(player_posX), .player_posY(player_posY),
        .facing_left(facing_left), .CounterX(CounterX), .CounterY(CounterY),
        .SwordBox(SwordBox), .sword_active(sword_active),
        .sword_state(sword_state), .swing_count(swing_count)
    );

    sword_hitbox #(
        .WINDUP_TICKS(0), .ACTIVE_TICKS(0), .COOLDOWN_TICKS(0)
    ) dutZero (
        .clk(clk), .rst(rst), .tick(tick), .attack_btn(attack_btn),
        .player_posX(player_posX), .player_posY(player_posY),
        .facing_left(facing_left), .CounterX(CounterX), .CounterY(CounterY),
        .SwordBox(zBox), .sword_active(zActive),
        .sword_state(zState), .swing_count(zCount)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a swing is a timeline measured in ticks since start.
    bit mInSwing;
    int mElapsed;
    bit mDir;
    int mCount;
    bit mPrev;

    function automatic int mPhase();
        if (!mInSwing) return 0;
        if (mElapsed < W) return 1;
        if (mElapsed < W + A) return 2;
        return 3;
    endfunction

    function automatic bit mBox();
        longint px = longint'(player_posX);
        longint py = longint'(player_posY);
        longint cx = longint'(CounterX);
        longint cy = longint'(CounterY);
        longint l, r, t, b;
        if (mDir) begin
            l = px - SW;
            if (l < 0) l = 0;
            r = px;
        end else begin
            l = px + 32;
            r = px + 32 + SW;
        end
        t = py - SYO - SH;
        if (t < 0) t = 0;
        b = py - SYO;
        if (b < 0) b = 0;
        return (mPhase() == 2) && cx >= l && cx < r && cy >= t && cy < b;
    endfunction

    // Reset treats the button as already held, so only a fresh press counts.
    task automatic modelEdge();
        if (rst) begin
            mInSwing = 0;
            mElapsed = 0;
            mDir     = 0;
            mCount   = 0;
            mPrev    = 1;
        end else begin
            if (!mInSwing) begin
                if (attack_btn && !mPrev) begin
                    mInSwing = 1;
                    mElapsed = 0;
                    mDir     = facing_left;
                    if (mCount < 255) mCount++;
                end
            end else if (tick) begin
                mElapsed++;
                if (mElapsed == W + A + C) mInSwing = 0;
            end
            mPrev = attack_btn;
        end
    endtask

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        check({tag, "_state"},  longint'(sword_state),  longint'(mPhase()));
        check({tag, "_active"}, longint'(sword_active), longint'(mPhase() == 2));
        check({tag, "_count"},  longint'(swing_count),  longint'(mCount));
        check({tag, "_box"},    longint'(SwordBox),     longint'(mBox()));
    endtask

    task automatic step(input string tag = "step");
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    task automatic doReset();
        rst        = 1'b1;
        attack_btn = 1'b0;
        tick       = 1'b0;
        step("rst");
        rst = 1'b0;
        step("post_rst");
    endtask

    task automatic enterActive(input bit d);
        doReset();
        facing_left = d;
        attack_btn  = 1'b1;
        step("ea_press");
        attack_btn = 1'b0;
        tick       = 1'b1;
        repeat (W) step("ea_tick");
        tick = 1'b0;
        check("enter_active", longint'(sword_state), 2);
    endtask

    typedef struct {
        bit dirL;
        int px;
        int py;
        int cx;
        int cy;
        bit exp;
    } boxVec_t;

    boxVec_t tbl [16];
    int      tw, ta, tc, curDir, savedCount;

    initial begin
        tbl[0]  = '{1'b0, 100, 200, 132, 176, 1'b1};
        tbl[1]  = '{1'b0, 100, 200, 156, 176, 1'b0};
        tbl[2]  = '{1'b0, 100, 200, 140, 184, 1'b0};
        tbl[3]  = '{1'b0, 100, 200, 140, 175, 1'b0};
        tbl[4]  = '{1'b0, 100, 200, 155, 183, 1'b1};
        tbl[5]  = '{1'b0, 100, 200, 131, 180, 1'b0};
        tbl[6]  = '{1'b1, 10,  200, 0,   180, 1'b1};
        tbl[7]  = '{1'b1, 10,  200, 10,  180, 1'b0};
        tbl[8]  = '{1'b1, 10,  200, 9,   183, 1'b1};
        tbl[9]  = '{1'b1, 0,   200, 0,   180, 1'b0};
        tbl[10] = '{1'b1, 0,   200, 5,   180, 1'b0};
        tbl[11] = '{1'b1, 100, 200, 76,  176, 1'b1};
        tbl[12] = '{1'b1, 100, 200, 75,  176, 1'b0};
        tbl[13] = '{1'b1, 100, 200, 99,  183, 1'b1};
        tbl[14] = '{1'b1, 100, 10,  80,  0,   1'b0};
        tbl[15] = '{1'b1, 100, 20,  80,  0,   1'b1};

        rst         = 1'b1;
        tick        = 1'b0;
        attack_btn  = 1'b0;
        facing_left = 1'b0;
        player_posX = 32'd100;
        player_posY = 32'd200;
        CounterX    = 32'd140;
        CounterY    = 32'd180;

        // Reset state
        step("rst0");
        check("rst_state",  longint'(sword_state),  0);
        check("rst_active", longint'(sword_active), 0);
        check("rst_count",  longint'(swing_count),  0);
        check("rst_box",    longint'(SwordBox),     0);
        rst = 1'b0;
        step("idle");

        // Full swing with a tick every 10 clocks
        attack_btn = 1'b1;
        step("sw_press");
        check("press_state", longint'(sword_state), 1);
        check("press_count", longint'(swing_count), 1);
        attack_btn = 1'b0;
        tw = 0; ta = 0; tc = 0;
        for (int i = 0; i < 1000; i++) begin
            tick = (i % 10 == 9);
            if (tick) begin
                case (sword_state)
                    2'd1: tw++;
                    2'd2: ta++;
                    2'd3: tc++;
                    default: ;
                endcase
            end
            step("sw");
            if (sword_state == 2'd0) break;
        end
        tick = 1'b0;
        check("ticks_windup",   tw, W);
        check("ticks_active",   ta, A);
        check("ticks_cooldown", tc, C);
        check("swing_end_state", longint'(sword_state), 0);
        check("swing_end_count", longint'(swing_count), 1);

        // Hitbox geometry table
        curDir = 2;
        for (int i = 0; i < 16; i++) begin
            if (int'(tbl[i].dirL) != curDir) begin
                enterActive(tbl[i].dirL);
                curDir = int'(tbl[i].dirL);
            end
            player_posX = 32'(tbl[i].px);
            player_posY = 32'(tbl[i].py);
            CounterX    = 32'(tbl[i].cx);
            CounterY    = 32'(tbl[i].cy);
            #1;
            check($sformatf("box_tbl%0d", i), longint'(SwordBox),
                  longint'(tbl[i].exp));
        end

        // Direction latched at swing start; press in COOLDOWN ignored
        enterActive(1'b0);
        player_posX = 32'd100;
        player_posY = 32'd200;
        CounterX    = 32'd140;
        CounterY    = 32'd180;
        step("dl");
        check("dl_box_before", longint'(SwordBox), 1);
        facing_left = 1'b1;
        step("dl");
        check("dl_box_after", longint'(SwordBox), 1);
        tick = 1'b1;
        repeat (A) step("dl_act");
        tick = 1'b0;
        check("dl_cooldown", longint'(sword_state), 3);
        check("dl_cd_box",   longint'(SwordBox),    0);
        savedCount = int'(swing_count);
        step("cd");
        attack_btn = 1'b1;
        step("cd_press");
        attack_btn = 1'b0;
        step("cd");
        check("cd_state", longint'(sword_state), 3);
        check("cd_count", longint'(swing_count), savedCount);
        tick = 1'b1;
        repeat (C) step("cd_tick");
        tick = 1'b0;
        check("cd_idle",  longint'(sword_state), 0);
        check("cd_count_end", longint'(swing_count), savedCount);

        // Reset mid-ACTIVE with the button held
        enterActive(1'b0);
        attack_btn = 1'b1;
        step("ra");
        rst = 1'b1;
        step("ra_rst");
        check("ra_state", longint'(sword_state), 0);
        check("ra_box",   longint'(SwordBox),    0);
        check("ra_count", longint'(swing_count), 0);
        rst = 1'b0;
        repeat (5) step("ra_held");
        check("ra_held_state", longint'(sword_state), 0);
        attack_btn = 1'b0;
        step("ra_rel");
        attack_btn = 1'b1;
        step("ra_press");
        check("ra_repress", longint'(sword_state), 1);
        attack_btn = 1'b0;

        // Press and tick in the same IDLE cycle
        doReset();
        attack_btn = 1'b1;
        tick       = 1'b1;
        step("pt_press");
        attack_btn = 1'b0;
        repeat (W - 1) step("pt_tick");
        check("pt_still_windup", longint'(sword_state), 1);
        step("pt_tick");
        tick = 1'b0;
        check("pt_active", longint'(sword_state), 2);

        // Zero-length phases behave as one tick
        doReset();
        attack_btn = 1'b1;
        step("z_press");
        check("zero_windup", longint'(zState), 1);
        attack_btn = 1'b0;
        tick       = 1'b1;
        step("z_t1");
        check("zero_active", longint'(zState), 2);
        check("zero_active_flag", longint'(zActive), 1);
        step("z_t2");
        check("zero_cooldown", longint'(zState), 3);
        step("z_t3");
        check("zero_idle", longint'(zState), 0);
        check("zero_count", longint'(zCount), 1);
        tick = 1'b0;

        // Saturation over 300 complete swings
        doReset();
        for (int s = 0; s < 300; s++) begin
            attack_btn = 1'b1;
            step("sat_press");
            attack_btn = 1'b0;
            tick       = 1'b1;
            repeat (W + A + C) step("sat_tick");
            tick = 1'b0;
        end
        check("sat_count", longint'(swing_count), 255);
        check("sat_state", longint'(sword_state), 0);

        // Randomized traffic against the model
        doReset();
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom % 300) == 0;
            tick = ($urandom % 3) == 0;
            if (($urandom % 6) == 0) attack_btn = ~attack_btn;
            if (($urandom % 4) == 0) facing_left = ~facing_left;
            if (($urandom % 50) == 0) begin
                case ($urandom % 5)
                    0: player_posX = 32'd0;
                    1: player_posX = 32'd10;
                    2: player_posX = 32'd24;
                    default: player_posX = 32'($urandom % 600);
                endcase
                case ($urandom % 5)
                    0: player_posY = 32'd10;
                    1: player_posY = 32'd20;
                    2: player_posY = 32'd24;
                    default: player_posY = 32'($urandom % 480);
                endcase
            end
            CounterX = player_posX + 32'($urandom_range(0, 100)) - 32'd40;
            CounterY = player_posY + 32'($urandom_range(0, 40)) - 32'd32;
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sword_hitbox.md
SWORD_HITBOX -- requirements
Module: sword_hitbox

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- WINDUP_TICKS, 4, tick count spent in WINDUP
- ACTIVE_TICKS, 12, tick count spent in ACTIVE
- COOLDOWN_TICKS, 20, tick count spent in COOLDOWN
- SWORD_W, 24, hitbox width in pixels
- SWORD_H, 8, hitbox height in pixels
- SWORD_YOFF, 16, hitbox bottom edge offset above player bottom
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single system clock (pixel clock domain)
- rst, in, 1, synchronous active-high reset
- tick, in, 1, one-cycle timing strobe from the slow game timer
- attack_btn, in, 1, attack button level, already synchronised to clk
- player_posX, in, 32, player left edge, screen coordinates, unsigned
- player_posY, in, 32, player bottom edge, screen coordinates, unsigned
- facing_left, in, 1, current player facing direction
- CounterX, in, 32, current VGA pixel X
- CounterY, in, 32, current VGA pixel Y
- SwordBox, out, 1, current pixel lies inside the live hitbox; feeds the mob kill logic
- sword_active, out, 1, FSM is in ACTIVE
- sword_state, out, 2, FSM state encoding
- swing_count, out, 8, number of swings started, saturating
REQ-003 clk and rst SHALL be the only clock and reset; all state updates on posedge clk; rst SHALL be sampled synchronously.

Function
REQ-004 FSM SHALL use states IDLE=0, WINDUP=1, ACTIVE=2, COOLDOWN=3, driven on sword_state.
REQ-005 A press SHALL be the rising edge of attack_btn: the current attack_btn is 1 and the previous cycle's registered value btn_q is 0.
REQ-006 In IDLE, a press SHALL move the FSM to WINDUP on the next clk, clear the tick counter, latch facing_left into dir_l, and increment swing_count (saturating at 255).
REQ-007 Presses outside IDLE SHALL be ignored and not queued; a held button SHALL NOT retrigger.
REQ-008 In WINDUP, ACTIVE and COOLDOWN, the tick counter SHALL increment on each cycle with tick=1.
REQ-009 When a tick arrives with counter == N-1 (N = that state's TICKS parameter), the FSM SHALL advance WINDUP->ACTIVE->COOLDOWN->IDLE and reset the counter to 0.
REQ-010 A parameter value of 0 SHALL behave as 1.
REQ-011 If a press and a tick occur in the same IDLE cycle, the tick SHALL NOT be counted toward WINDUP.
REQ-012 sword_active SHALL equal (sword_state == ACTIVE) and is a registered output.
REQ-013 Hitbox X range when dir_l=1: [max(player_posX - SWORD_W, 0), player_posX). Subtraction underflow SHALL clamp the left edge to 0; if player_posX = 0 the box SHALL be empty.
REQ-014 Hitbox X range when dir_l=0: [player_posX + 32, player_posX + 32 + SWORD_W).
REQ-015 Hitbox Y range: [player_posY - SWORD_YOFF - SWORD_H, player_posY - SWORD_YOFF), with the same clamping to 0.
REQ-016 All hitbox comparisons SHALL be 32-bit unsigned.
REQ-017 SwordBox SHALL be combinational from CounterX, CounterY, player_posX, player_posY and the registered state/dir_l, giving zero-cycle latency that is pixel-aligned with the mob draw signal.
REQ-018 SwordBox SHALL be 0 in every state other than ACTIVE.
REQ-019 Player position SHALL be used live; only the direction is latched, at swing start.

Reset
REQ-020 On rst=1 at posedge clk: sword_state=IDLE, tick counter=0, btn_q=0, dir_l=0, swing_count=0, sword_active=0. SwordBox is therefore 0 on the following cycle.
REQ-021 rst asserted mid-swing SHALL abort to IDLE immediately.
REQ-022 After rst deasserts, a button already held high SHALL NOT register as a press until it is released and pressed again.

Verification
REQ-023 Single press, defaults, tick every 10 clk: WINDUP for 4 ticks, ACTIVE for 12, COOLDOWN for 20, then IDLE; swing_count=1.
REQ-024 Box position: player_posX=100, player_posY=200, facing_left=0, FSM in ACTIVE. Pixel (132,176) -> SwordBox=1; (156,176) -> 0; (140,184) -> 0; (140,175) -> 0.
REQ-025 Left-edge clamp: player_posX=10, facing_left=1, FSM in ACTIVE. Pixel (0,y_in) -> SwordBox=1; (10,y_in) -> 0. With player_posX=0 -> SwordBox=0 at every pixel.
REQ-026 Direction latch and ignored press: facing_left toggles during ACTIVE -> box side unchanged. A second press during COOLDOWN -> no new swing; swing_count unchanged.
REQ-027 Reset mid-ACTIVE with attack_btn held: the next cycle shows IDLE, SwordBox=0, swing_count=0. No swing starts until attack_btn goes 0 and then 1.
REQ-028 Saturation: 300 presses, each fully completing a swing -> swing_count=255.
